// File: rtl/regfile_mp_sb_if.sv
// Register-file bus: decode-side read/claim ports, writeback-side write ports,
// and the scoreboard view returned to the pipeline.
interface regfile_mp_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) ();
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;
  logic              rd_busy0;
  logic              rd_busy1;

  logic              wr_en0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [DATA_W-1:0] wr_data0;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data1;

  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic [DEPTH-1:0]  busy_vec;

  modport master (
    output rd_addr0, rd_addr1, wr_en0, wr_addr0, wr_data0,
           wr_en1, wr_addr1, wr_data1, claim_en, claim_addr,
    input  rd_data0, rd_data1, rd_busy0, rd_busy1, busy_vec
  );

  modport slave (
    input  rd_addr0, rd_addr1, wr_en0, wr_addr0, wr_data0,
           wr_en1, wr_addr1, wr_data1, claim_en, claim_addr,
    output rd_data0, rd_data1, rd_busy0, rd_busy1, busy_vec
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Two-read / two-write register file with per-register pending scoreboard,
// optional write-to-read bypass and optional hardwired-zero register 0.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input logic            clk,
  input logic            rst,
  regfile_mp_sb_if.slave bus
);
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NREAD  = 2;

  logic [DATA_W-1:0] regs     [DEPTH];
  logic [DATA_W-1:0] regs_nxt [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic [ADDR_W-1:0] ra     [NREAD];
  logic [DATA_W-1:0] data_c [NREAD];
  logic              busy_c [NREAD];

  // Per-register next state: port 1 overrides port 0, a claim overrides any write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_nxt[i] = regs[i];
      busy_nxt[i] = busy[i];
      if (bus.wr_en0 && (bus.wr_addr0 == ADDR_W'(i))) begin
        regs_nxt[i] = bus.wr_data0;
        busy_nxt[i] = 1'b0;
      end
      if (bus.wr_en1 && (bus.wr_addr1 == ADDR_W'(i))) begin
        regs_nxt[i] = bus.wr_data1;
        busy_nxt[i] = 1'b0;
      end
      if (bus.claim_en && (bus.claim_addr == ADDR_W'(i))) begin
        busy_nxt[i] = 1'b1;
      end
      if ((ZERO_REG != 0) && (i == 0)) begin
        regs_nxt[i] = '0;
        busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= regs_nxt[i];
      end
      busy <= busy_nxt;
    end
  end

  assign ra[0] = bus.rd_addr0;
  assign ra[1] = bus.rd_addr1;

  // Combinational read: forwarded write data and a completing write hide the
  // pending bit unless a new producer is claiming the same register.
  always_comb begin
    for (int k = 0; k < NREAD; k++) begin
      data_c[k] = regs[ra[k]];
      busy_c[k] = busy[ra[k]];
      if (BYPASS != 0) begin
        if (bus.wr_en1 && (bus.wr_addr1 == ra[k])) begin
          data_c[k] = bus.wr_data1;
        end else if (bus.wr_en0 && (bus.wr_addr0 == ra[k])) begin
          data_c[k] = bus.wr_data0;
        end
        if (((bus.wr_en1 && (bus.wr_addr1 == ra[k])) ||
             (bus.wr_en0 && (bus.wr_addr0 == ra[k]))) &&
            !(bus.claim_en && (bus.claim_addr == ra[k]))) begin
          busy_c[k] = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (ra[k] == '0)) begin
        data_c[k] = '0;
        busy_c[k] = 1'b0;
      end
    end
  end

  assign bus.rd_data0 = data_c[0];
  assign bus.rd_data1 = data_c[1];
  assign bus.rd_busy0 = busy_c[0];
  assign bus.rd_busy1 = busy_c[1];
  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: three configurations (bypass, no bypass, bypass+zero reg)
// driven in lockstep and compared against an array-based reference model.
module tb_regfile_mp_sb;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NC = 3;
  // cfg0: BYPASS=1 ZERO_REG=0, cfg1: BYPASS=0 ZERO_REG=0, cfg2: BYPASS=1 ZERO_REG=1
  localparam bit [2:0] BP = 3'b101;
  localparam bit [2:0] ZR = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wr_en0, wr_en1, claim_en;
  logic [AW-1:0] wr_addr0, wr_addr1, claim_addr, rd_addr0, rd_addr1;
  logic [DW-1:0] wr_data0, wr_data1;

  logic [DW-1:0] got_d0 [NC];
  logic [DW-1:0] got_d1 [NC];
  logic          got_b0 [NC];
  logic          got_b1 [NC];
  logic [15:0]   got_vec [NC];

  regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW)) ifs [NC] ();

  for (genvar g = 0; g < NC; g++) begin : g_conn
    assign ifs[g].rd_addr0   = rd_addr0;
    assign ifs[g].rd_addr1   = rd_addr1;
    assign ifs[g].wr_en0     = wr_en0;
    assign ifs[g].wr_addr0   = wr_addr0;
    assign ifs[g].wr_data0   = wr_data0;
    assign ifs[g].wr_en1     = wr_en1;
    assign ifs[g].wr_addr1   = wr_addr1;
    assign ifs[g].wr_data1   = wr_data1;
    assign ifs[g].claim_en   = claim_en;
    assign ifs[g].claim_addr = claim_addr;
    assign got_d0[g]  = ifs[g].rd_data0;
    assign got_d1[g]  = ifs[g].rd_data1;
    assign got_b0[g]  = ifs[g].rd_busy0;
    assign got_b1[g]  = ifs[g].rd_busy1;
    assign got_vec[g] = ifs[g].busy_vec;
  end

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifs[0]));
  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifs[1]));
  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifs[2]));

  // Reference model: stored values and pending bits (register 0 forced at read time).
  logic [DW-1:0] mem [16];
  logic [15:0]   bm;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          we0; bit [3:0] wa0; bit [15:0] wd0;
    bit          we1; bit [3:0] wa1; bit [15:0] wd1;
    bit          ce;  bit [3:0] ca;
    bit [3:0]    ra0; bit [3:0] ra1;
    bit [15:0]   ea_rd0;   // cfg0 rd_data0 in the cycle
    bit [15:0]   eb_rd0;   // cfg1 rd_data0 in the cycle
    bit          ea_busy1; // cfg0 rd_busy1 in the cycle
    bit [15:0]   ea_vec;   // cfg0 busy_vec after the edge
  } vec_t;

  vec_t tbl [10];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bm = '0;
  endtask

  task automatic model_step();
    if (wr_en0) begin mem[wr_addr0] = wr_data0; bm[wr_addr0] = 1'b0; end
    if (wr_en1) begin mem[wr_addr1] = wr_data1; bm[wr_addr1] = 1'b0; end
    if (claim_en) bm[claim_addr] = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_data(int c, logic [AW-1:0] a);
    if (ZR[c] && a == 4'd0) return '0;
    if (BP[c]) begin
      if (wr_en1 && wr_addr1 == a) return wr_data1;
      if (wr_en0 && wr_addr0 == a) return wr_data0;
    end
    return mem[a];
  endfunction

  function automatic logic exp_busy(int c, logic [AW-1:0] a);
    if (ZR[c] && a == 4'd0) return 1'b0;
    if (BP[c] && ((wr_en1 && wr_addr1 == a) || (wr_en0 && wr_addr0 == a)) &&
        !(claim_en && claim_addr == a)) return 1'b0;
    return bm[a];
  endfunction

  function automatic logic [15:0] exp_vec(int c);
    logic [15:0] v;
    v = bm;
    if (ZR[c]) v[0] = 1'b0;
    return v;
  endfunction

  task automatic cmp(input string nm, input int c, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cfg%0d: got %h expected %h at %0t", nm, c, got, exp, $time);
    end
  endtask

  task automatic check();
    for (int c = 0; c < NC; c++) begin
      cmp("rd_data0", c, got_d0[c], exp_data(c, rd_addr0));
      cmp("rd_data1", c, got_d1[c], exp_data(c, rd_addr1));
      cmp("rd_busy0", c, 16'(got_b0[c]), 16'(exp_busy(c, rd_addr0)));
      cmp("rd_busy1", c, 16'(got_b1[c]), 16'(exp_busy(c, rd_addr1)));
      cmp("busy_vec", c, got_vec[c], exp_vec(c));
    end
  endtask

  task automatic set_in(input bit we0, input bit [3:0] wa0, input bit [15:0] wd0,
                        input bit we1, input bit [3:0] wa1, input bit [15:0] wd1,
                        input bit ce, input bit [3:0] ca, input bit [3:0] ra0, input bit [3:0] ra1);
    wr_en0 = we0; wr_addr0 = wa0; wr_data0 = wd0;
    wr_en1 = we1; wr_addr1 = wa1; wr_data1 = wd1;
    claim_en = ce; claim_addr = ca;
    rd_addr0 = ra0; rd_addr1 = ra1;
  endtask

  // Returns 1 time unit after the rising edge with the model advanced.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) model_step();
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3, 16'hBEEF, 16'h0000, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, 1'b0, 4'd0, 4'd5, 4'd5, 16'h2222, 16'h0000, 1'b0, 16'h0000};
    tbl[3] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd5, 16'h2222, 16'h2222, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd7, 16'h0000, 16'h0000, 1'b0, 16'h0080};
    tbl[5] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd7, 16'h0000, 16'h0000, 1'b1, 16'h0080};
    tbl[6] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h00A5, 1'b0, 4'd0, 4'd7, 4'd7, 16'h00A5, 16'h0000, 1'b0, 16'h0000};
    tbl[7] = '{1'b1, 4'd7, 16'h5A5A, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd7, 16'h5A5A, 16'h00A5, 1'b0, 16'h0080};
    tbl[8] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd7, 16'h5A5A, 16'h5A5A, 1'b1, 16'h0080};
    tbl[9] = '{1'b1, 4'd3, 16'h0001, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd3, 4'd7, 16'h0001, 16'hBEEF, 1'b1, 16'h0080};

    rst = 1'b1;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on every address, both ports.
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(15 - i));
      #1;
      cmp("reset rd_data0", 0, got_d0[0], 16'h0000);
      check();
    end
    tick();

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      set_in(tbl[v].we0, tbl[v].wa0, tbl[v].wd0, tbl[v].we1, tbl[v].wa1, tbl[v].wd1,
             tbl[v].ce, tbl[v].ca, tbl[v].ra0, tbl[v].ra1);
      #1;
      cmp("tbl rd_data0 bypass", 0, got_d0[0], tbl[v].ea_rd0);
      cmp("tbl rd_data0 nobypass", 1, got_d0[1], tbl[v].eb_rd0);
      cmp("tbl rd_busy1", 0, 16'(got_b1[0]), 16'(tbl[v].ea_busy1));
      check();
      tick();
      cmp("tbl busy_vec", 0, got_vec[0], tbl[v].ea_vec);
    end

    // Hardwired zero: write and claim r0 on both ports.
    set_in(1, 0, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    #1;
    cmp("zero rd_data0", 2, got_d0[2], 16'h0000);
    cmp("zero rd_busy0", 2, 16'(got_b0[2]), 16'h0000);
    check();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    cmp("zero busy_vec0", 2, 16'(got_vec[2][0]), 16'h0000);
    cmp("zero rd_data1", 2, got_d1[2], 16'h0000);
    check();
    tick();

    // Asynchronous reset between edges; a write under reset is not kept.
    set_in(1, 2, 16'h1234, 0, 0, 0, 1, 9, 2, 9);
    #1 check();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 2, 9);
    #1;
    cmp("preload r2", 0, got_d0[0], 16'h1234);
    cmp("preload busy r9", 0, 16'(got_b1[0]), 16'h0001);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    cmp("async rst r2", 0, got_d0[0], 16'h0000);
    cmp("async rst busy_vec", 0, got_vec[0], 16'h0000);
    check();
    set_in(1, 4, 16'h7777, 0, 0, 0, 1, 4, 4, 9);
    #1;
    cmp("rst bypass r4", 0, got_d0[0], 16'h7777);
    cmp("rst nobypass r4", 1, got_d0[1], 16'h0000);
    check();
    tick();
    #2;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 4, 4);
    #1;
    cmp("rst write dropped", 0, got_d0[0], 16'h0000);
    cmp("rst claim dropped", 0, got_vec[0], 16'h0000);
    check();
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(31) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      set_in(1'($urandom_range(1)), 4'($urandom), 16'($urandom),
             1'($urandom_range(1)), 4'($urandom), 16'($urandom),
             1'($urandom_range(1)), 4'($urandom), 4'($urandom), 4'($urandom));
      #1 check();
      tick();
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the 16x16 two-read/one-write register file.
- Provides two combinational read ports and two synchronous write ports with fixed write priority, optional write-to-read bypass, and an optional hardwired-zero register.
- Adds a per-register scoreboard (pending/busy bit) so the pipeline can detect RAW hazards on registers with an outstanding producer.
- Sits between decode (reads, claims) and writeback (writes); plain driven outputs, no tri-state bitlines.

Parameters:
- DATA_W, 16, width of each register in bits.
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and claims, and is never busy.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rd_addr0  input  ADDR_W  read port 0 address.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_data0  output  DATA_W  read port 0 data.
- rd_data1  output  DATA_W  read port 1 data.
- rd_busy0  output  1  scoreboard bit for rd_addr0 after bypass.
- rd_busy1  output  1  scoreboard bit for rd_addr1 after bypass.
- wr_en0  input  1  write port 0 enable.
- wr_addr0  input  ADDR_W  write port 0 address.
- wr_data0  input  DATA_W  write port 0 data.
- wr_en1  input  1  write port 1 enable; higher priority than port 0.
- wr_addr1  input  ADDR_W  write port 1 address.
- wr_data1  input  DATA_W  write port 1 data.
- claim_en  input  1  mark claim_addr as pending (producer issued).
- claim_addr  input  ADDR_W  register to claim.
- busy_vec  output  DEPTH  registered scoreboard, bit i = register i pending.

Behaviour:
- Reset:
  - On rst high, asynchronously and without waiting for a clock edge: all registers = 0, busy_vec = 0.
  - Read outputs are combinational, so during reset rd_data* = 0 and rd_busy* = 0, except that with BYPASS=1 an asserted write forwards its data to a matching read.
  - Writes and claims are ignored while rst is high.
- Writes:
  - At the rising edge, reg[wr_addrN] <= wr_dataN for each enabled port.
  - If both ports are enabled to the same address, port 1 data is stored; port 0 is discarded.
- Reads:
  - Combinational, zero latency.
  - BYPASS=1: if wr_en1 and wr_addr1 == rd_addrK, rd_dataK = wr_data1; otherwise, if wr_en0 and wr_addr0 == rd_addrK, rd_dataK = wr_data0; otherwise the stored value.
  - BYPASS=0: always the stored value, so a write is visible the cycle after it is presented.
  - Both read ports may address the same register; each returns identical data.
- Scoreboard update at the rising edge, evaluated per register i:
  - claim_en and claim_addr == i: busy[i] <= 1. A claim wins over a same-cycle write to i, because a new producer supersedes the completing one.
  - else, any enabled write to i: busy[i] <= 0.
  - else, busy[i] holds.
  - Claiming an already-busy register keeps it at 1; writing a non-busy register leaves it at 0.
- rd_busyK:
  - Equals busy_vec[rd_addrK].
  - With BYPASS=1 it is forced to 0 when a same-cycle write hits rd_addrK and no same-cycle claim targets rd_addrK.
  - With BYPASS=0 it is the raw registered bit.
- ZERO_REG=1:
  - reg 0 and busy_vec[0] are held at 0.
  - rd_dataK = 0 and rd_busyK = 0 whenever rd_addrK = 0, including under bypass.
- Storage is flops; no X may propagate from unwritten registers because of the reset.

Test Plan:
- Reset, then read all 16 addresses on both ports -> every rd_data = 0x0000, busy_vec = 0x0000.
- Write 0xBEEF to r3 via port 0 with rd_addr0=3 in the same cycle, BYPASS=1 -> rd_data0 = 0xBEEF in that cycle and after the edge. With BYPASS=0 -> old value 0x0000 in that cycle, 0xBEEF the next cycle.
- Same cycle, wr_en0 r5=0x1111 and wr_en1 r5=0x2222 -> rd_data on r5 = 0x2222 in the write cycle (bypass) and after the edge.
- Claim r7 -> busy_vec[7]=1 and rd_busy1=1 for rd_addr1=7.
  - Next cycle: write r7=0x00A5 with no claim -> rd_busy1=0 in the write cycle (bypass) and busy_vec[7]=0 after the edge.
  - Then: claim r7 and write r7 in the same cycle -> busy_vec[7]=1 after the edge.
- ZERO_REG=1: write 0xFFFF to r0 and claim r0 -> rd_data=0x0000, busy_vec[0]=0, rd_busy=0, including in the write cycle.
- Load r2=0x1234 and claim r9, then assert rst mid-cycle, between clock edges -> registers and busy_vec clear immediately; a write presented while rst is high is not stored after rst drops.
